// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit: 32-step iterative shift-add multiply and
// restoring divide, plus MTHI/MTLO writes; fixed 32-cycle latency.
module mips_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 6;
    localparam int unsigned LAST = 31;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    opnd;
    logic [W-1:0]    acc_hi;
    logic [W-1:0]    acc_lo;

    logic            sgn;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;

    logic [W:0]      add_sum;
    logic [W:0]      sh_rem;
    logic [W-1:0]    sub_rem;
    logic            ge;
    logic [2*W-1:0]  mul_next;
    logic [W-1:0]    nxt_hi;
    logic [W-1:0]    nxt_lo;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    res_hi;
    logic [W-1:0]    res_lo;

    // Operand magnitudes for the signed ops, taken straight from the inputs
    always_comb begin
        sgn   = ~op[0];
        mag_a = (sgn && a[W-1]) ? W'(-a) : a;
        mag_b = (sgn && b[W-1]) ? W'(-b) : b;
    end

    // One iteration: multiply shifts the accumulator right, divide shifts left
    always_comb begin
        add_sum  = {1'b0, acc_hi} + {1'b0, opnd};
        sh_rem   = {acc_hi, acc_lo[W-1]};
        ge       = (sh_rem >= {1'b0, opnd});
        sub_rem  = sh_rem[W-1:0] - opnd;
        mul_next = acc_lo[0] ? {add_sum, acc_lo[W-1:1]}
                             : {1'b0, acc_hi, acc_lo[W-1:1]};
        if (is_div) begin
            nxt_hi = ge ? sub_rem : sh_rem[W-1:0];
            nxt_lo = {acc_lo[W-2:0], ge};
        end else begin
            nxt_hi = mul_next[2*W-1:W];
            nxt_lo = mul_next[W-1:0];
        end
    end

    // Sign correction applied to the final step's values as HI/LO are loaded
    always_comb begin
        prod   = {nxt_hi, nxt_lo};
        res_hi = nxt_hi;
        res_lo = nxt_lo;
        if (is_div) begin
            if (opnd == '0) begin
                res_hi = a_r;
                res_lo = '1;
            end else begin
                res_lo = neg_q ? W'(-nxt_lo) : nxt_lo;
                res_hi = neg_r ? W'(-nxt_hi) : nxt_hi;
            end
        end else if (neg_q) begin
            {res_hi, res_lo} = (2*W)'(-prod);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_r    <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_q  <= sgn & (a[W-1] ^ b[W-1]);
                        neg_r  <= sgn & a[W-1];
                        a_r    <= a;
                        acc_hi <= '0;
                        opnd   <= op[1] ? mag_b : mag_a;
                        acc_lo <= op[1] ? mag_a : mag_b;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    if (cnt == CW'(LAST)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed MIPS cases plus random ops
// against an arithmetic reference model.
module tb_mips_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mips_muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference {HI,LO} from MIPS arithmetic rules
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int     ix, iy, q, r;
        logic [63:0] res;
        ix = x;
        iy = y;
        sx = ix;
        sy = iy;
        case (o)
            2'd0: res = sx * sy;
            2'd1: res = {32'h0, x} * {32'h0, y};
            2'd2: begin
                if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q = ix / iy;
                    r = ix % iy;
                    res = {r, q};
                end
            end
            default: begin
                if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issue one operation and verify latency, HI/LO hold, result and single done pulse
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        logic [31:0] h0, l0;
        int lat;
        bit held;
        e = model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        h0 = hi; l0 = lo;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", busy, 1);
        lat = 0;
        held = 1'b1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!done && (hi !== h0 || lo !== l0 || !busy)) held = 1'b0;
        end
        check("latency", lat, 32);
        check("hold_busy", held, 1);
        check("busy_fall", busy, 0);
        check("hi", hi, e[63:32]);
        check("lo", lo, e[31:0]);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
    endtask

    initial begin
        int lat, l2, ndone, c1, c2, c3;
        bit lo_ok;
        logic [31:0] h0, x, y;
        logic [1:0] o;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        #3 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hilo", {hi, lo}, 64'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Directed arithmetic cases
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd3, 32'd100, 32'd0);
        run_op(2'd2, 32'hFFFF_FF00, 32'd0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            run_op(o, x, y);
        end

        // Start and MTHI during busy are ignored
        @(negedge clk);
        op = 2'd1; a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
        h0 = hi;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'd5; b = 32'd1; mthi = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("ovl_hi_hold", hi, h0);
        check("ovl_busy", busy, 1);
        wait_done(lat);
        check("ovl_latency", 10 + lat, 32);
        check("ovl_result", {hi, lo}, 64'h0000_0001_0000_0000);

        // MTHI after done, then MTHI+MTLO together
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'h0);
        check("mthi_nodone", done, 0);
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mtboth", {hi, lo}, {32'hABCD, 32'hABCD});
        check("mtboth_nodone", done, 0);

        // Start wins over MTHI on the same edge
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2; mthi = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("prio_hi", hi, 32'hABCD);
        check("prio_busy", busy, 1);
        wait_done(lat);
        check("prio_result", {hi, lo}, 64'h4);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd5;
        ndone = 0; c1 = -1; c2 = -1; c3 = -1; lo_ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (ndone == 1) c1 = c;
                if (ndone == 2) c2 = c;
                if (ndone == 3) c3 = c;
                if (lo !== 32'd15 || hi !== 32'd0) lo_ok = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_count", ndone, 3);
        check("b2b_first", c1, 32);
        check("b2b_second", c2, 65);
        check("b2b_third", c3, 98);
        check("b2b_result", lo_ok, 1);
        wait_done(lat);
        check("b2b_tail", done, 1);

        // Asynchronous reset mid-divide
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        wait_done(l2);
        check("arst_no_result", done, 0);
        run_op(2'd1, 32'd3, 32'd5);
        check("arst_mul", {hi, lo}, 64'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock shared with the MIPS core
- rst  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled on a rising clk edge
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- mthi  in  1  write wdata into HI
- mtlo  in  1  write wdata into LO
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress; the core stalls MFHI/MFLO/new mul-div while high
- done  out  1  one-cycle pulse when HI/LO receive a new result
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-003 Start acceptance SHALL occur only when start=1 and busy=0 at a rising edge.
- The block SHALL capture a, b and op on that edge.
- busy SHALL read 1 from the following cycle.
REQ-004 Timing of an accepted operation SHALL be fixed:
- Iteration steps occur on the next 32 edges (E1..E32), one bit per edge.
- At E32 HI/LO are loaded, busy falls to 0 and done is 1 for exactly one cycle.
- Start-to-result latency is 32 cycles, independent of operand values.
REQ-005 Multiply SHALL be iterative shift-add on 32-bit magnitudes, producing a 64-bit product.
- Result: {HI,LO} = product.
- For MULT, operands SHALL be treated as two's complement.
- For MULT, the product SHALL be negated when the operand signs differ.
REQ-006 Divide SHALL be iterative restoring division on 32-bit magnitudes.
- Result: LO = quotient, HI = remainder.
- For DIV, the quotient SHALL be negated when the operand signs differ.
- For DIV, the remainder SHALL take the sign of the dividend.
REQ-007 Divide by zero SHALL still take 32 cycles and SHALL produce HI = a, LO = 0xFFFF_FFFF (both DIV and DIVU).
REQ-008 DIV of 0x8000_0000 by 0xFFFF_FFFF SHALL produce LO = 0x8000_0000, HI = 0, with no other side effect.
REQ-009 start asserted while busy=1 SHALL be ignored (no queueing); the running operation SHALL be unaffected.
REQ-010 mthi/mtlo SHALL write HI/LO on the edge only when busy=0 and no start is accepted on that edge.
- Otherwise they SHALL be ignored; start has priority.
- mthi and mtlo together SHALL write both registers.
- done SHALL NOT pulse for mthi/mtlo writes.
REQ-011 hi/lo SHALL hold their last values throughout busy; intermediate iteration state SHALL NOT be visible on hi/lo.
REQ-012 The state machine SHALL have exactly two states:
- IDLE -> RUN on accepted start.
- RUN -> IDLE after the 32nd step.
- A 6-bit step counter SHALL count 0..31.
REQ-013 A start accepted on the same edge that done is asserted SHALL be legal: busy is 0 in that cycle, so the new operation begins immediately and done is a single pulse.

Reset
REQ-014 rst=0 SHALL immediately, without a clock edge, force state IDLE, busy=0, done=0, hi=0, lo=0 and the step counter to 0.
REQ-015 rst asserted mid-operation SHALL abandon the operation with no partial result written; after rst deasserts the block SHALL accept a new start normally.

Verification
REQ-016 MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> after 32 cycles HI=0xFFFF_FFFE, LO=0x0000_0001, done pulses once, busy high exactly 32 cycles.
REQ-017 MULT a=0xFFFF_FFFD (-3), b=7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB (-21).
REQ-018 DIV a=-7 (0xFFFF_FFF9), b=2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); then DIVU a=100, b=0 -> HI=100, LO=0xFFFF_FFFF.
REQ-019 Overlap test: start at cycle 10 during busy -> ignored. mthi (wdata=0x1234) while busy -> HI unchanged. mthi after done -> HI=0x0000_1234, no done pulse.
REQ-020 Back-to-back test: start held high continuously -> a new operation is accepted every 33 cycles, done pulses once per operation.
REQ-021 Reset test: rst pulled low at step 15 of a DIV -> busy, done, hi and lo read 0 asynchronously. After release, MULTU 3x5 -> LO=15, HI=0.
